// File: rtl/cond_unit_mt_pkg.sv
// Shared types for the multi-context condition unit: condition encodings,
// flag bit positions and the packed flag record.
package cond_unit_mt_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/cond_unit_mt_if.sv
// Flag-write, EX-stage request and registered-result signals of cond_unit_mt.
interface cond_unit_mt_if #(
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  parameter int CNT_W   = 16
);
  logic             flag_we;
  logic [CTX_W-1:0] flag_ctx;
  logic [3:0]       flag_mask;
  logic [3:0]       flag_in;
  logic             ex_valid;
  logic [CTX_W-1:0] ex_ctx;
  logic [3:0]       ex_cond;
  logic             stall;
  logic             flush;
  logic             cond_valid_o;
  logic             cond_pass_o;
  logic [3:0]       cond_flags_o;
  logic [CNT_W-1:0] squash_cnt_o;

  modport master (
    output flag_we, flag_ctx, flag_mask, flag_in,
    output ex_valid, ex_ctx, ex_cond, stall, flush,
    input  cond_valid_o, cond_pass_o, cond_flags_o, squash_cnt_o
  );

  modport slave (
    input  flag_we, flag_ctx, flag_mask, flag_in,
    input  ex_valid, ex_ctx, ex_cond, stall, flush,
    output cond_valid_o, cond_pass_o, cond_flags_o, squash_cnt_o
  );
endinterface

// File: rtl/cond_unit_mt_eval.sv
// Combinational ARM condition-code evaluator; code 4'hF behaves as always.
module cond_eval
  import cond_unit_mt_pkg::*;
(
  input  logic [3:0] cond_i,
  input  flags_t     flags_i,
  output logic       pass_o
);

  logic nv_eq_s;

  // Decode the condition field against the supplied flags
  always_comb begin
    nv_eq_s = (flags_i.n == flags_i.v);
    pass_o  = 1'b1;
    case (cond_e'(cond_i))
      EQ:      pass_o = flags_i.z;
      NE:      pass_o = !flags_i.z;
      CS:      pass_o = flags_i.c;
      CC:      pass_o = !flags_i.c;
      MI:      pass_o = flags_i.n;
      PL:      pass_o = !flags_i.n;
      VS:      pass_o = flags_i.v;
      VC:      pass_o = !flags_i.v;
      HI:      pass_o = flags_i.c && !flags_i.z;
      LS:      pass_o = !flags_i.c || flags_i.z;
      GE:      pass_o = nv_eq_s;
      LT:      pass_o = !nv_eq_s;
      GT:      pass_o = !flags_i.z && nv_eq_s;
      LE:      pass_o = flags_i.z || !nv_eq_s;
      AL:      pass_o = 1'b1;
      NV:      pass_o = 1'b1;
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit_mt.sv
// Multi-context flag bank with same-cycle bypass, registered execute/squash
// decision and a saturating squash counter.
module cond_unit_mt
  import cond_unit_mt_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  cond_unit_mt_if.slave bus
);

  flags_t           flags_q [NUM_CTX];
  flags_t           flags_d [NUM_CTX];
  flags_t           base_s;
  flags_t           eff_s;
  logic             ctx_hit_s;
  logic             pass_s;
  logic             capture_s;
  logic             valid_q, valid_d;
  logic             pass_q, pass_d;
  flags_t           fl_q, fl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Masked flag-bank update; an out-of-range context matches no entry
  always_comb begin
    for (int k = 0; k < NUM_CTX; k++) begin
      flags_d[k] = flags_q[k];
      if (bus.flag_we && (bus.flag_ctx == CTX_W'(k))) begin
        flags_d[k] = (flags_q[k] & ~bus.flag_mask) | (bus.flag_in & bus.flag_mask);
      end else begin
        flags_d[k] = flags_q[k];
      end
    end
  end

  // Select EX context flags and bypass a same-cycle write to that context
  always_comb begin
    base_s    = '0;
    ctx_hit_s = 1'b0;
    for (int k = 0; k < NUM_CTX; k++) begin
      if (bus.ex_ctx == CTX_W'(k)) begin
        base_s    = flags_q[k];
        ctx_hit_s = 1'b1;
      end else begin
        base_s    = base_s;
      end
    end
    if (ctx_hit_s && bus.flag_we && (bus.flag_ctx == bus.ex_ctx)) begin
      eff_s = (base_s & ~bus.flag_mask) | (bus.flag_in & bus.flag_mask);
    end else begin
      eff_s = base_s;
    end
  end

  cond_eval u_eval (
    .cond_i (bus.ex_cond),
    .flags_i(eff_s),
    .pass_o (pass_s)
  );

  // Pipeline register next state: flush beats stall beats capture
  always_comb begin
    capture_s = !bus.flush && !bus.stall;
    valid_d   = valid_q;
    pass_d    = pass_q;
    fl_d      = fl_q;
    cnt_d     = cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (capture_s) begin
      valid_d = bus.ex_valid;
      if (bus.ex_valid) begin
        pass_d = pass_s;
        fl_d   = eff_s;
        if (!pass_s && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        pass_d = pass_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CTX; k++) begin
        flags_q[k] <= '0;
      end
      valid_q <= 1'b0;
      pass_q  <= 1'b0;
      fl_q    <= '0;
      cnt_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_CTX; k++) begin
        flags_q[k] <= flags_d[k];
      end
      valid_q <= valid_d;
      pass_q  <= pass_d;
      fl_q    <= fl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.cond_valid_o = valid_q;
  assign bus.cond_pass_o  = pass_q;
  assign bus.cond_flags_o = fl_q;
  assign bus.squash_cnt_o = cnt_q;

endmodule

// File: tb/tb_cond_unit_mt.sv
// Directed bench for cond_unit_mt: 3 contexts (leaves id 3 out of range) and
// a 4-bit squash counter so saturation is reachable.
module tb_cond_unit_mt;
  localparam int NUM_CTX = 3;
  localparam int CTX_W   = 2;
  localparam int CNT_W   = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cond_unit_mt_if #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W), .CNT_W(CNT_W)) bus ();

  cond_unit_mt #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string tag, input logic v, input logic p,
                     input logic [3:0] f, input logic [3:0] c);
    check({tag, ".valid"}, 32'(bus.cond_valid_o), 32'(v));
    check({tag, ".pass"},  32'(bus.cond_pass_o),  32'(p));
    check({tag, ".flags"}, 32'(bus.cond_flags_o), 32'(f));
    check({tag, ".cnt"},   32'(bus.squash_cnt_o), 32'(c));
  endtask

  task automatic wr(input logic we, input logic [1:0] ctx, input logic [3:0] m, input logic [3:0] d);
    bus.flag_we = we; bus.flag_ctx = ctx; bus.flag_mask = m; bus.flag_in = d;
  endtask

  task automatic ex(input logic v, input logic [1:0] ctx, input logic [3:0] c);
    bus.ex_valid = v; bus.ex_ctx = ctx; bus.ex_cond = c;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    wr(1'b0, 2'd0, 4'h0, 4'h0);
    ex(1'b0, 2'd0, 4'h0);
    bus.stall = 1'b0; bus.flush = 1'b0;
    step(); step();
    out("reset", 1'b0, 1'b0, 4'h0, 4'h0);

    rst = 1'b0;
    ex(1'b1, 2'd0, 4'h0);                      // EQ on Z=0
    step(); out("eq_fail", 1'b1, 1'b0, 4'h0, 4'h1);

    ex(1'b0, 2'd0, 4'h0); wr(1'b1, 2'd2, 4'hF, 4'b0100);
    step(); out("idle", 1'b0, 1'b0, 4'h0, 4'h1);
    wr(1'b0, 2'd0, 4'h0, 4'h0);
    ex(1'b1, 2'd2, 4'h0);
    step(); out("ctx2_eq", 1'b1, 1'b1, 4'b0100, 4'h1);
    ex(1'b1, 2'd1, 4'h0);
    step(); out("ctx1_eq", 1'b1, 1'b0, 4'b0000, 4'h2);

    wr(1'b1, 2'd1, 4'b0001, 4'b1111); ex(1'b1, 2'd1, 4'h6);   // bypass VS
    step(); out("bypass_vs", 1'b1, 1'b1, 4'b0001, 4'h2);
    wr(1'b0, 2'd0, 4'h0, 4'h0); ex(1'b1, 2'd1, 4'h7);
    step(); out("commit_vc", 1'b1, 1'b0, 4'b0001, 4'h3);

    wr(1'b1, 2'd0, 4'hF, 4'b1001); ex(1'b0, 2'd0, 4'h0);
    step();
    wr(1'b0, 2'd0, 4'h0, 4'h0);
    ex(1'b1, 2'd0, 4'hA); step(); out("ge", 1'b1, 1'b1, 4'b1001, 4'h3);
    ex(1'b1, 2'd0, 4'hB); step(); out("lt", 1'b1, 1'b0, 4'b1001, 4'h4);
    ex(1'b1, 2'd0, 4'hC); step(); out("gt", 1'b1, 1'b1, 4'b1001, 4'h4);
    wr(1'b1, 2'd0, 4'b0100, 4'b0100); ex(1'b1, 2'd0, 4'hD);
    step(); out("le_bypass", 1'b1, 1'b1, 4'b1101, 4'h4);
    wr(1'b0, 2'd0, 4'h0, 4'h0);
    ex(1'b1, 2'd0, 4'h8); step(); out("hi", 1'b1, 1'b0, 4'b1101, 4'h5);
    ex(1'b1, 2'd0, 4'h9); step(); out("ls", 1'b1, 1'b1, 4'b1101, 4'h5);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex(1'b1, 2'd0, 4'(i + 1));
      step(); out("stall", 1'b1, 1'b1, 4'b1101, 4'h5);
    end
    bus.flush = 1'b1; ex(1'b1, 2'd0, 4'h1);
    step(); out("stall_flush", 1'b0, 1'b1, 4'b1101, 4'h5);
    bus.stall = 1'b0;
    step(); out("flush", 1'b0, 1'b1, 4'b1101, 4'h5);
    bus.flush = 1'b0;

    ex(1'b1, 2'd3, 4'h0); step(); out("oor_eq", 1'b1, 1'b0, 4'h0, 4'h6);
    wr(1'b1, 2'd3, 4'hF, 4'b0100);
    step(); out("oor_nobypass", 1'b1, 1'b0, 4'h0, 4'h7);
    wr(1'b0, 2'd0, 4'h0, 4'h0);
    ex(1'b1, 2'd3, 4'hE); step(); out("al", 1'b1, 1'b1, 4'h0, 4'h7);
    ex(1'b1, 2'd3, 4'hF); step(); out("nv_as_al", 1'b1, 1'b1, 4'h0, 4'h7);
    ex(1'b1, 2'd0, 4'h4); step(); out("ctx0_kept", 1'b1, 1'b1, 4'b1101, 4'h7);

    ex(1'b1, 2'd1, 4'h0);
    for (int i = 0; i < 8; i++) step();
    out("cnt_at_max", 1'b1, 1'b0, 4'b0001, 4'hF);
    for (int i = 0; i < 9; i++) step();
    out("cnt_saturated", 1'b1, 1'b0, 4'b0001, 4'hF);

    bus.stall = 1'b1; rst = 1'b1;
    step(); out("rst_mid_stall", 1'b0, 1'b0, 4'h0, 4'h0);
    rst = 1'b0; bus.stall = 1'b0; ex(1'b1, 2'd0, 4'h4);
    step(); out("after_rst", 1'b1, 1'b0, 4'h0, 4'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
